// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Holds the loader state encoding, the instruction word width and the default
// end-of-program (halt) word, which the debug unit also uses.
package uart_program_loader_pkg;

  localparam int unsigned WordWidth = 32;

  // Word value that ends a program image; also recognised as the halt word.
  localparam logic [WordWidth-1:0] DefaultEndWord = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/uart_program_loader.sv
// Boot-time program loader.
// Packs bytes from the UART receiver into little-endian 32-bit words and writes
// them to consecutive instruction-memory addresses. Loading stops after the
// end-of-program word has been written or after the last address is filled.
//
// Ports:
//   clock, reset  - system clock, asynchronous active-high reset
//   start         - arm the loader (honoured only while idle or done)
//   rx_done_tick  - one-cycle strobe, data_in holds a received byte
//   data_in       - received byte
//   mem_we        - one-cycle instruction-memory write enable
//   mem_addr      - word write address
//   mem_wdata     - word to write
//   loading       - loader is accepting bytes
//   done          - loading finished
//   overflow      - memory filled without seeing the end word
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH = 10,
  parameter logic [WordWidth-1:0]    END_WORD   = DefaultEndWord
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_done_tick,
  input  logic [7:0]            data_in,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WordWidth-1:0]  mem_wdata,
  output logic                  loading,
  output logic                  done,
  output logic                  overflow
);

  state_e                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [23:0]            asm_q, asm_d;
  logic                   we_q, we_d;
  logic [WordWidth-1:0]   wdata_q, wdata_d;
  logic                   ovf_q, ovf_d;

  logic [WordWidth-1:0]   word_full;
  logic                   word_tick;
  logic                   last_addr;

  // The fourth byte goes straight into the registered write data.
  assign word_full = {data_in, asm_q};
  assign word_tick = rx_done_tick && (cnt_q == 2'd3);
  assign last_addr = (addr_q == {ADDR_WIDTH{1'b1}});

  // State register and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: if (word_tick && ((word_full == END_WORD) || last_addr)) state_d = StDone;
      StDone: if (start) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: byte assembly, write strobe and address stepping.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          cnt_d  = 2'd0;
          addr_d = '0;
          asm_d  = '0;
          ovf_d  = 1'b0;
        end
      end
      StLoad: begin
        // A write pulse in LOAD means the loader continues, so step the address
        // once the pulse has presented it.
        if (we_q) addr_d = addr_q + ADDR_WIDTH'(1);
        if (rx_done_tick) begin
          cnt_d = cnt_q + 2'd1;
          case (cnt_q)
            2'd0: asm_d[7:0]   = data_in;
            2'd1: asm_d[15:8]  = data_in;
            2'd2: asm_d[23:16] = data_in;
            default: begin
              we_d    = 1'b1;
              wdata_d = word_full;
              // The end word wins over a full memory.
              if ((word_full != END_WORD) && last_addr) ovf_d = 1'b1;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    loading   = (state_q == StLoad);
    done      = (state_q == StDone);
    overflow  = ovf_q;
  end

endmodule
